// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: NMASTER masters share one slave port, with grant held
// for the whole bus cycle and a per-access watchdog that aborts unacknowledged strobes.

module wb_arbiter_lane #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              sel,
  input  logic              m_cyc,
  input  logic              m_stb,
  input  logic              m_we,
  input  logic [AWIDTH-1:0] m_adr,
  input  logic [DWIDTH-1:0] m_dat,
  output logic              g_cyc,
  output logic              g_stb,
  output logic              g_we,
  output logic [AWIDTH-1:0] g_adr,
  output logic [DWIDTH-1:0] g_dat
);
  // Grant-gated fields; the top ORs all lanes, so non-owners must contribute zero.
  assign g_cyc = sel & m_cyc;
  assign g_stb = sel & m_cyc & m_stb;
  assign g_we  = sel & m_we;
  assign g_adr = {AWIDTH{sel}} & m_adr;
  assign g_dat = {DWIDTH{sel}} & m_dat;
endmodule

module wb_arbiter #(
  parameter int NMASTER = 4,
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      hclk,
  input  logic                      hresetn,
  input  logic [NMASTER-1:0]        m_cyc_i,
  input  logic [NMASTER-1:0]        m_stb_i,
  input  logic [NMASTER-1:0]        m_we_i,
  input  logic [NMASTER*AWIDTH-1:0] m_adr_i,
  input  logic [NMASTER*DWIDTH-1:0] m_dat_i,
  output logic [DWIDTH-1:0]         m_dat_o,
  output logic [NMASTER-1:0]        m_ack_o,
  output logic [NMASTER-1:0]        m_err_o,
  output logic [NMASTER-1:0]        gnt_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [AWIDTH-1:0]         s_adr_o,
  output logic [DWIDTH-1:0]         s_dat_o,
  input  logic [DWIDTH-1:0]         s_dat_i,
  input  logic                      s_ack_i
);
  localparam int LW = $clog2(NMASTER);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;

  state_t             state_q, state_d;
  logic [NMASTER-1:0] gnt_q, gnt_d;
  logic [NMASTER-1:0] err_q, err_d;
  logic [LW-1:0]      last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [NMASTER-1:0]             cyc_l, stb_l, we_l;
  logic [NMASTER-1:0][AWIDTH-1:0] adr_l;
  logic [NMASTER-1:0][DWIDTH-1:0] dat_l;

  for (genvar i = 0; i < NMASTER; i++) begin : g_lane
    wb_arbiter_lane #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_lane (
      .sel   (gnt_q[i]),
      .m_cyc (m_cyc_i[i]),
      .m_stb (m_stb_i[i]),
      .m_we  (m_we_i[i]),
      .m_adr (m_adr_i[i*AWIDTH +: AWIDTH]),
      .m_dat (m_dat_i[i*DWIDTH +: DWIDTH]),
      .g_cyc (cyc_l[i]),
      .g_stb (stb_l[i]),
      .g_we  (we_l[i]),
      .g_adr (adr_l[i]),
      .g_dat (dat_l[i])
    );
  end

  // gnt_q is non-zero only in OWN, so the OR of gated lanes is the owner's view.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    for (int i = 0; i < NMASTER; i++) begin
      s_cyc_o = s_cyc_o | cyc_l[i];
      s_stb_o = s_stb_o | stb_l[i];
      s_we_o  = s_we_o  | we_l[i];
      s_adr_o = s_adr_o | adr_l[i];
      s_dat_o = s_dat_o | dat_l[i];
    end
  end

  assign m_ack_o = gnt_q & {NMASTER{s_ack_i & s_stb_o}};
  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt_q;
  assign m_err_o = err_q;

  // Round-robin search starting just above the most recent owner.
  logic [LW-1:0] win, cand;
  logic          win_vld;

  always_comb begin
    win     = '0;
    cand    = '0;
    win_vld = 1'b0;
    for (int k = 1; k <= NMASTER; k++) begin
      cand = LW'((int'(last_q) + k) % NMASTER);
      if (!win_vld && m_cyc_i[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
  end

  logic arb;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = '0;
    err_d   = '0;
    arb     = 1'b0;
    unique case (state_q)
      IDLE:  arb = |m_cyc_i;
      OWN: begin
        if (!m_cyc_i[last_q]) begin
          arb = 1'b1;
        end else if (s_stb_o && !s_ack_i) begin
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_d       = ABORT;
            gnt_d         = '0;
            err_d[last_q] = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ABORT: arb = 1'b1;
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    if (arb) begin
      gnt_d = '0;
      if (win_vld) begin
        state_d    = OWN;
        gnt_d[win] = 1'b1;
        last_d     = win;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      err_q   <= '0;
      last_q  <= LW'(NMASTER - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: per-cycle vector table plus timeout, late-ack and
// asynchronous-reset sequences.

module tb_wb_arbiter;
  logic        hclk = 1'b0;
  logic        hresetn;
  logic [3:0]  m_cyc_i, m_stb_i, m_we_i;
  logic [127:0] m_adr_i, m_dat_i;
  logic [31:0] m_dat_o;
  logic [3:0]  m_ack_o, m_err_o, gnt_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_ack_i;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  wb_arbiter #(.NMASTER(4), .AWIDTH(32), .DWIDTH(32), .TIMEOUT(16)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .gnt_o(gnt_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  typedef struct {
    logic [3:0]  cyc, stb, we;
    logic        ack;
    logic [31:0] sdat;
    logic [3:0]  gnt;
    logic        scyc, sstb, swe;
    logic [31:0] sadr, sdato;
    logic [3:0]  mack;
  } vec_t;

  vec_t tv [28];

  function automatic vec_t mk(input logic [3:0] cyc, stb, we, input logic ack,
                              input logic [31:0] sdat, input logic [3:0] gnt,
                              input logic scyc, sstb, swe,
                              input logic [31:0] sadr, sdato, input logic [3:0] mack);
    vec_t r;
    r = '{cyc, stb, we, ack, sdat, gnt, scyc, sstb, swe, sadr, sdato, mack};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic [3:0] c, s, w, input logic a, input logic [31:0] d);
    m_cyc_i = c; m_stb_i = s; m_we_i = w; s_ack_i = a; s_dat_i = d;
  endtask

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  initial begin
    // Master i: addresses 10/08/40/30, write data AAAA/1234/5555/7777
    m_adr_i = {32'h30, 32'h40, 32'h08, 32'h10};
    m_dat_i = {32'h7777, 32'h5555, 32'h1234, 32'hAAAA};
    hresetn = 1'b0;
    drv(4'h0, 4'h0, 4'h0, 1'b0, 32'h0);

    //             cyc    stb    we     ack   sdat          gnt    cyc  stb  we   sadr    sdato      mack
    tv[0]  = mk(4'h0, 4'h0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0,1'b0,1'b0, 32'h0,  32'h0,     4'h0);
    tv[1]  = mk(4'hB, 4'h0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0,1'b0,1'b0, 32'h0,  32'h0,     4'h0);
    tv[2]  = mk(4'hB, 4'hB, 4'h0, 1'b1, 32'h0,        4'h1, 1'b1,1'b1,1'b0, 32'h10, 32'hAAAA,  4'h1);
    tv[3]  = mk(4'hA, 4'hA, 4'h0, 1'b0, 32'h0,        4'h1, 1'b0,1'b0,1'b0, 32'h10, 32'hAAAA,  4'h0);
    tv[4]  = mk(4'hB, 4'hB, 4'h0, 1'b1, 32'h0,        4'h2, 1'b1,1'b1,1'b0, 32'h08, 32'h1234,  4'h2);
    tv[5]  = mk(4'h9, 4'h9, 4'h0, 1'b0, 32'h0,        4'h2, 1'b0,1'b0,1'b0, 32'h08, 32'h1234,  4'h0);
    tv[6]  = mk(4'hB, 4'hB, 4'h0, 1'b1, 32'h0,        4'h8, 1'b1,1'b1,1'b0, 32'h30, 32'h7777,  4'h8);
    tv[7]  = mk(4'h3, 4'h3, 4'h0, 1'b0, 32'h0,        4'h8, 1'b0,1'b0,1'b0, 32'h30, 32'h7777,  4'h0);
    tv[8]  = mk(4'hB, 4'hB, 4'h0, 1'b1, 32'h0,        4'h1, 1'b1,1'b1,1'b0, 32'h10, 32'hAAAA,  4'h1);
    tv[9]  = mk(4'hA, 4'hA, 4'h0, 1'b0, 32'h0,        4'h1, 1'b0,1'b0,1'b0, 32'h10, 32'hAAAA,  4'h0);
    tv[10] = mk(4'hB, 4'hB, 4'h0, 1'b1, 32'h0,        4'h2, 1'b1,1'b1,1'b0, 32'h08, 32'h1234,  4'h2);
    tv[11] = mk(4'h9, 4'h9, 4'h0, 1'b0, 32'h0,        4'h2, 1'b0,1'b0,1'b0, 32'h08, 32'h1234,  4'h0);
    tv[12] = mk(4'hB, 4'hB, 4'h0, 1'b1, 32'h0,        4'h8, 1'b1,1'b1,1'b0, 32'h30, 32'h7777,  4'h8);
    tv[13] = mk(4'h0, 4'h0, 4'h0, 1'b0, 32'h0,        4'h8, 1'b0,1'b0,1'b0, 32'h30, 32'h7777,  4'h0);
    tv[14] = mk(4'h0, 4'h0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0,1'b0,1'b0, 32'h0,  32'h0,     4'h0);
    tv[15] = mk(4'h4, 4'h0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0,1'b0,1'b0, 32'h0,  32'h0,     4'h0);
    tv[16] = mk(4'h4, 4'h4, 4'h0, 1'b0, 32'h0,        4'h4, 1'b1,1'b1,1'b0, 32'h40, 32'h5555,  4'h0);
    tv[17] = mk(4'h4, 4'h4, 4'h0, 1'b0, 32'h0,        4'h4, 1'b1,1'b1,1'b0, 32'h40, 32'h5555,  4'h0);
    tv[18] = mk(4'h4, 4'h4, 4'h0, 1'b0, 32'h0,        4'h4, 1'b1,1'b1,1'b0, 32'h40, 32'h5555,  4'h0);
    tv[19] = mk(4'h4, 4'h4, 4'h0, 1'b1, 32'hDEADBEEF, 4'h4, 1'b1,1'b1,1'b0, 32'h40, 32'h5555,  4'h4);
    tv[20] = mk(4'h0, 4'h0, 4'h0, 1'b0, 32'h0,        4'h4, 1'b0,1'b0,1'b0, 32'h40, 32'h5555,  4'h0);
    tv[21] = mk(4'h0, 4'h0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0,1'b0,1'b0, 32'h0,  32'h0,     4'h0);
    tv[22] = mk(4'h2, 4'h0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0,1'b0,1'b0, 32'h0,  32'h0,     4'h0);
    tv[23] = mk(4'h3, 4'h3, 4'h2, 1'b1, 32'h0,        4'h2, 1'b1,1'b1,1'b1, 32'h08, 32'h1234,  4'h2);
    tv[24] = mk(4'h1, 4'h1, 4'h0, 1'b0, 32'h0,        4'h2, 1'b0,1'b0,1'b0, 32'h08, 32'h1234,  4'h0);
    tv[25] = mk(4'h1, 4'h1, 4'h0, 1'b1, 32'h0,        4'h1, 1'b1,1'b1,1'b0, 32'h10, 32'hAAAA,  4'h1);
    tv[26] = mk(4'h0, 4'h0, 4'h0, 1'b0, 32'h0,        4'h1, 1'b0,1'b0,1'b0, 32'h10, 32'hAAAA,  4'h0);
    tv[27] = mk(4'h0, 4'h0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0,1'b0,1'b0, 32'h0,  32'h0,     4'h0);

    // Reset: requests while held in reset must not grant
    repeat (2) @(posedge hclk);
    #1 drv(4'hF, 4'hF, 4'h0, 1'b1, 32'h0);
    @(posedge hclk);
    #1;
    chk("rst_gnt",  {28'h0, gnt_o}, 32'h0);
    chk("rst_scyc", {31'h0, s_cyc_o}, 32'h0);
    chk("rst_ack",  {28'h0, m_ack_o}, 32'h0);
    chk("rst_err",  {28'h0, m_err_o}, 32'h0);
    drv(4'h0, 4'h0, 4'h0, 1'b0, 32'h0);
    @(negedge hclk) hresetn = 1'b1;
    tick();

    for (int i = 0; i < 28; i++) begin
      drv(tv[i].cyc, tv[i].stb, tv[i].we, tv[i].ack, tv[i].sdat);
      @(negedge hclk);
      chk($sformatf("v%0d_gnt", i),  {28'h0, gnt_o},   {28'h0, tv[i].gnt});
      chk($sformatf("v%0d_scyc", i), {31'h0, s_cyc_o}, {31'h0, tv[i].scyc});
      chk($sformatf("v%0d_sstb", i), {31'h0, s_stb_o}, {31'h0, tv[i].sstb});
      chk($sformatf("v%0d_swe", i),  {31'h0, s_we_o},  {31'h0, tv[i].swe});
      chk($sformatf("v%0d_sadr", i), s_adr_o, tv[i].sadr);
      chk($sformatf("v%0d_sdat", i), s_dat_o, tv[i].sdato);
      chk($sformatf("v%0d_mack", i), {28'h0, m_ack_o}, {28'h0, tv[i].mack});
      chk($sformatf("v%0d_err", i),  {28'h0, m_err_o}, 32'h0);
      if (tv[i].mack != 4'h0)
        chk($sformatf("v%0d_mdat", i), m_dat_o, tv[i].sdat);
      tick();
    end

    // Timeout: master 0 never acked while master 1 waits
    drv(4'h1, 4'h0, 4'h0, 1'b0, 32'h0);
    tick();
    for (int c = 0; c < 16; c++) begin
      drv(4'h3, 4'h3, 4'h0, 1'b0, 32'h0);
      @(negedge hclk);
      chk($sformatf("to_c%0d_err", c),  {28'h0, m_err_o}, 32'h0);
      chk($sformatf("to_c%0d_gnt", c),  {28'h0, gnt_o},   32'h1);
      chk($sformatf("to_c%0d_scyc", c), {31'h0, s_cyc_o}, 32'h1);
      tick();
    end
    @(negedge hclk);
    chk("to_c16_err",  {28'h0, m_err_o}, 32'h1);
    chk("to_c16_scyc", {31'h0, s_cyc_o}, 32'h0);
    chk("to_c16_gnt",  {28'h0, gnt_o},   32'h0);
    tick();
    drv(4'h3, 4'h3, 4'h0, 1'b1, 32'h0);
    @(negedge hclk);
    chk("to_c17_gnt",  {28'h0, gnt_o},   32'h2);
    chk("to_c17_err",  {28'h0, m_err_o}, 32'h0);
    chk("to_c17_mack", {28'h0, m_ack_o}, 32'h2);
    chk("to_c17_sadr", s_adr_o, 32'h08);
    tick();
    drv(4'h0, 4'h0, 4'h0, 1'b0, 32'h0);
    tick();

    // Ack lands in the cycle where the watchdog sits at TIMEOUT-1
    drv(4'h1, 4'h0, 4'h0, 1'b0, 32'h0);
    tick();
    for (int c = 0; c < 15; c++) begin
      drv(4'h1, 4'h1, 4'h0, 1'b0, 32'h0);
      @(negedge hclk);
      chk($sformatf("la_c%0d_err", c), {28'h0, m_err_o}, 32'h0);
      tick();
    end
    drv(4'h1, 4'h1, 4'h0, 1'b1, 32'h0);
    @(negedge hclk);
    chk("la_c15_mack", {28'h0, m_ack_o}, 32'h1);
    tick();
    drv(4'h1, 4'h0, 4'h0, 1'b0, 32'h0);
    @(negedge hclk);
    chk("la_c16_gnt", {28'h0, gnt_o},   32'h1);
    chk("la_c16_err", {28'h0, m_err_o}, 32'h0);
    tick();
    drv(4'h0, 4'h0, 4'h0, 1'b0, 32'h0);
    @(negedge hclk);
    chk("la_c17_err", {28'h0, m_err_o}, 32'h0);
    tick();
    tick();

    // Asynchronous reset in the middle of an acked strobe; last owner returns to NMASTER-1
    drv(4'h1, 4'h1, 4'h0, 1'b0, 32'h0);
    tick();
    s_ack_i = 1'b1;
    #1;
    chk("mr_pre_scyc", {31'h0, s_cyc_o}, 32'h1);
    chk("mr_pre_mack", {28'h0, m_ack_o}, 32'h1);
    #1 hresetn = 1'b0;
    #1;
    chk("mr_scyc", {31'h0, s_cyc_o}, 32'h0);
    chk("mr_sstb", {31'h0, s_stb_o}, 32'h0);
    chk("mr_mack", {28'h0, m_ack_o}, 32'h0);
    chk("mr_gnt",  {28'h0, gnt_o},   32'h0);
    drv(4'hF, 4'h0, 4'h0, 1'b0, 32'h0);
    @(negedge hclk) hresetn = 1'b1;
    tick();
    @(negedge hclk);
    chk("mr_last_gnt", {28'h0, gnt_o}, 32'h1);
    drv(4'h0, 4'h0, 4'h0, 1'b0, 32'h0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
